// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - multi-cycle restoring divider, one quotient bit per clock
//
// Purpose:
//   Produces quotient and remainder by iterated trial subtraction.
//   With the default build, operands are unsigned. Define SEQ_DIV_SIGNED_EN
//   for two's-complement operands: the quotient truncates toward zero and
//   the remainder takes the dividend's sign.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        division request, sampled only in IDLE
//   dividend     numerator, sampled with start
//   divisor      denominator, sampled with start
//   busy         high in CALC and DONE
//   done         one-cycle pulse, results valid
//   quotient     result quotient, held until the next result
//   remainder    result remainder, held until the next result
//   div_by_zero  latched divisor was zero, held with the results
//
// Optional feature macro: SEQ_DIV_SIGNED_EN
module seq_restoring_divider #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   p_r;      // partial remainder
  logic [W-1:0]   q_r;      // dividend bits shifting out, quotient bits shifting in
  logic [W-1:0]   dvs_r;    // divisor (magnitude in signed builds)
  logic [W-1:0]   dvd_r;    // raw dividend, returned as remainder on divide-by-zero
  logic [CW-1:0]  cnt_r;
  logic           zero_r;

  logic [W:0]     shifted;
  logic [W:0]     trial;
  logic           trial_neg;
  logic [W-1:0]   p_nxt;
  logic [W-1:0]   q_nxt;
  logic [W-1:0]   q_res;
  logic [W-1:0]   r_res;
  logic [W-1:0]   dvd_mag;
  logic [W-1:0]   dvs_mag;

`ifdef SEQ_DIV_SIGNED_EN
  logic           neg_q_r;
  logic           neg_r_r;

  assign dvd_mag = dividend[W-1] ? (~dividend + 1'b1) : dividend;
  assign dvs_mag = divisor[W-1]  ? (~divisor + 1'b1)  : divisor;
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
`endif

  // One restoring step: shift {P,Q} left, subtract the divisor W+1 bits wide
  // so the borrow bit alone tells whether the trial went negative.
  always_comb begin
    shifted   = {p_r, q_r[W-1]};
    trial     = shifted - {1'b0, dvs_r};
    trial_neg = trial[W];
    p_nxt     = trial_neg ? shifted[W-1:0] : trial[W-1:0];
    q_nxt     = {q_r[W-2:0], ~trial_neg};
  end

  // Final result as loaded on the edge that enters DONE.
  always_comb begin
    q_res = q_nxt;
    r_res = p_nxt;
`ifdef SEQ_DIV_SIGNED_EN
    if (neg_q_r) q_res = ~q_nxt + 1'b1;
    if (neg_r_r) r_res = ~p_nxt + 1'b1;
`endif
    if (zero_r) begin
      q_res = '1;
      r_res = dvd_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: begin
        busy = 1'b1;
        if (cnt_r == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r         <= '0;
      q_r         <= '0;
      dvs_r       <= '0;
      dvd_r       <= '0;
      cnt_r       <= '0;
      zero_r      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            p_r    <= '0;
            q_r    <= dvd_mag;
            dvs_r  <= dvs_mag;
            dvd_r  <= dividend;
            zero_r <= (divisor == '0);
            // A zero divisor spends a single CALC cycle so done follows one
            // clock after the start edge; the iteration result is overridden.
            cnt_r  <= (divisor == '0) ? CW'(1) : CW'(W);
`ifdef SEQ_DIV_SIGNED_EN
            neg_q_r <= dividend[W-1] ^ divisor[W-1];
            neg_r_r <= dividend[W-1];
`endif
          end
        end
        CALC: begin
          p_r   <= p_nxt;
          q_r   <= q_nxt;
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            quotient    <= q_res;
            remainder   <= r_res;
            div_by_zero <= zero_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - self-checking bench for seq_restoring_divider
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [3:0] quotient, remainder;

  int tests = 0;
  int fails = 0;

  seq_restoring_divider #(.W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic on the operand values.
  function automatic void model(input logic [3:0] a, input logic [3:0] b,
                                output logic [3:0] q, output logic [3:0] r, output logic z);
    int sa, sb;
    if (b == 4'd0) begin
      q = 4'hF; r = a; z = 1'b1;
    end else begin
`ifdef SEQ_DIV_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
`else
      sa = int'(a);
      sb = int'(b);
`endif
      q = 4'(sa / sb);
      r = 4'(sa % sb);
      z = 1'b0;
    end
  endfunction

  // Issues one division and returns results, edges from start edge to done, busy cycles.
  task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                         output logic [3:0] q, output logic [3:0] r, output logic z,
                         output int lat, output int nbusy);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dividend = 4'($urandom); divisor = 4'($urandom);
    lat = 0; nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (busy) nbusy++;
    q = quotient; r = remainder; z = div_by_zero;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    tests++; if ({busy, done, div_by_zero} !== 3'b000) begin fails++;
      $display("FAIL reset_flags busy/done/dbz=%b required 000", {busy, done, div_by_zero}); end
    tests++; if ({quotient, remainder} !== 8'h00) begin fails++;
      $display("FAIL reset_results q/r=%h required 00", {quotient, remainder}); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [3:0] q, r; logic z; int lat, nb;
    run_div(4'd13, 4'd3, q, r, z, lat, nb);
    tests++; if (lat !== 4) begin fails++; $display("FAIL basic_latency got %0d required 4", lat); end
    tests++; if (q !== 4'd4) begin fails++; $display("FAIL basic_q got %0d required 4", q); end
    tests++; if (r !== 4'd1) begin fails++; $display("FAIL basic_r got %0d required 1", r); end
    tests++; if (z !== 1'b0) begin fails++; $display("FAIL basic_dbz got %b required 0", z); end
    tests++; if (nb !== 5) begin fails++; $display("FAIL basic_busy_cycles got %0d required 5", nb); end
    tests++; if ({done, busy} !== 2'b00) begin fails++;
      $display("FAIL basic_after_done done/busy=%b required 00", {done, busy}); end
    tests++; if ({quotient, remainder} !== {4'd4, 4'd1}) begin fails++;
      $display("FAIL basic_hold got %h required 41", {quotient, remainder}); end
  endtask

  task automatic test_reset_mid;
    logic [3:0] q, r; logic z; int lat, nb; bit seen;
    @(negedge clk);
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({busy, done, div_by_zero, quotient, remainder} !== 11'd0) begin fails++;
      $display("FAIL midreset_outputs got %h required 000", {busy, done, div_by_zero, quotient, remainder}); end
    seen = 0;
    repeat (2) begin @(negedge clk); if (done) seen = 1; end
    rst_n = 1'b1;
    repeat (6) begin @(negedge clk); if (done) seen = 1; end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL midreset_no_done got done pulse required none"); end
    run_div(4'd6, 4'd2, q, r, z, lat, nb);
    tests++; if ({q, r} !== {4'd3, 4'd0}) begin fails++;
      $display("FAIL midreset_fresh got q=%0d r=%0d required q=3 r=0", q, r); end
  endtask

  task automatic test_boundaries;
    logic [3:0] a [3] = '{4'd15, 4'd5, 4'd15};
    logic [3:0] b [3] = '{4'd1, 4'd7, 4'd15};
    logic [3:0] eq [3] = '{4'd15, 4'd0, 4'd1};
    logic [3:0] er [3] = '{4'd0, 4'd5, 4'd0};
    logic [3:0] q, r; logic z; int lat, nb;
    for (int i = 0; i < 3; i++) begin
      run_div(a[i], b[i], q, r, z, lat, nb);
      tests++; if ({q, r, z} !== {eq[i], er[i], 1'b0} || lat !== 4) begin fails++;
        $display("FAIL boundary_%0d/%0d got q=%0d r=%0d z=%b lat=%0d required q=%0d r=%0d z=0 lat=4",
                 a[i], b[i], q, r, z, lat, eq[i], er[i]); end
    end
  endtask

  task automatic test_div_by_zero;
    logic [3:0] q, r; logic z; int lat, nb;
    run_div(4'd9, 4'd0, q, r, z, lat, nb);
    tests++; if (lat !== 1) begin fails++; $display("FAIL dbz_latency got %0d required 1", lat); end
    tests++; if ({q, r, z} !== {4'hF, 4'd9, 1'b1}) begin fails++;
      $display("FAIL dbz_result got q=%h r=%0d z=%b required q=f r=9 z=1", q, r, z); end
    tests++; if (div_by_zero !== 1'b1) begin fails++; $display("FAIL dbz_hold got %b required 1", div_by_zero); end
    run_div(4'd8, 4'd2, q, r, z, lat, nb);
    tests++; if ({q, r, z} !== {4'd4, 4'd0, 1'b0}) begin fails++;
      $display("FAIL dbz_next got q=%0d r=%0d z=%b required q=4 r=0 z=0", q, r, z); end
  endtask

  task automatic test_ignore_start;
    int lat;
    @(negedge clk);
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); dividend = 4'd2; divisor = 4'd1; start = 1'b1;
    @(negedge clk); start = 1'b0; lat = 2;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    tests++; if ({quotient, remainder, lat[3:0]} !== {4'd4, 4'd1, 4'd4}) begin fails++;
      $display("FAIL ignore_start got q=%0d r=%0d lat=%0d required q=4 r=1 lat=4", quotient, remainder, lat); end
    @(negedge clk);
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ignore_start_queued busy=%b required 0", busy); end
  endtask

  task automatic test_random;
    logic [3:0] a, b, q, r, eq, er; logic z, ez; int lat, nb;
    for (int i = 0; i < 40; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      model(a, b, eq, er, ez);
      run_div(a, b, q, r, z, lat, nb);
      tests++; if ({q, r, z} !== {eq, er, ez}) begin fails++;
        $display("FAIL random_%h/%h got q=%h r=%h z=%b required q=%h r=%h z=%b", a, b, q, r, z, eq, er, ez); end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] eq, er; logic ez; int cyc; logic [7:0] pairs [256];
    for (int i = 0; i < 256; i++) pairs[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      int j; logic [7:0] t;
      j = $urandom_range(0, i);
      t = pairs[i]; pairs[i] = pairs[j]; pairs[j] = t;
    end
    @(negedge clk);
    {dividend, divisor} = pairs[0]; start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!done && cyc < 20);
      model(pairs[i][7:4], pairs[i][3:0], eq, er, ez);
      tests++; if (!done || {quotient, remainder, div_by_zero} !== {eq, er, ez}) begin fails++;
        $display("FAIL sweep_%h/%h got done=%b q=%h r=%h z=%b required q=%h r=%h z=%b",
                 pairs[i][7:4], pairs[i][3:0], done, quotient, remainder, div_by_zero, eq, er, ez); end
      if (i < 255) {dividend, divisor} = pairs[i+1];
    end
    start = 1'b0;
    @(negedge clk);
  endtask

`ifdef SEQ_DIV_SIGNED_EN
  task automatic test_signed;
    logic [3:0] q, r; logic z; int lat, nb;
    run_div(4'h9, 4'd2, q, r, z, lat, nb);
    tests++; if ({q, r} !== {4'hD, 4'hF}) begin fails++;
      $display("FAIL signed_m7_2 got q=%h r=%h required q=d r=f", q, r); end
    run_div(4'd7, 4'hE, q, r, z, lat, nb);
    tests++; if ({q, r} !== {4'hD, 4'h1}) begin fails++;
      $display("FAIL signed_7_m2 got q=%h r=%h required q=d r=1", q, r); end
    run_div(4'h8, 4'hF, q, r, z, lat, nb);
    tests++; if ({q, r, z} !== {4'h8, 4'h0, 1'b0}) begin fails++;
      $display("FAIL signed_min_m1 got q=%h r=%h z=%b required q=8 r=0 z=0", q, r, z); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_reset_mid();
    test_boundaries();
    test_div_by_zero();
    test_ignore_start();
`ifdef SEQ_DIV_SIGNED_EN
    test_signed();
`endif
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
